// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and helpers for the BRAM port arbiter
package bram_arb_pkg;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    localparam int WORD_BYTES = 4;

    // Overlay the strobed bytes of new_data onto base.
    function automatic logic [8*WORD_BYTES-1:0] merge_bytes(
        input logic [8*WORD_BYTES-1:0] base,
        input logic [8*WORD_BYTES-1:0] new_data,
        input logic [WORD_BYTES-1:0]   strb
    );
        logic [8*WORD_BYTES-1:0] res;
        res = base;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter, pointer moves only on contention
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    req_id_e prio_q, prio_d;

    always_comb begin
        gnt_o  = req_i;
        prio_d = prio_q;
        if (req_i == 2'b11) begin
            // Favour the side that lost the previous contention, then hand priority over.
            if (prio_q == REQ_IFU) begin
                gnt_o  = 2'b01;
                prio_d = REQ_LSU;
            end else begin
                gnt_o  = 2'b10;
                prio_d = REQ_IFU;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= REQ_IFU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares a dual-port BRAM between the IFU and the LSU
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clka,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_rsp_valid,
    output logic [31:0]           ifu_rsp_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_req_write,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic [31:0]           lsu_req_wdata,
    input  logic [3:0]            lsu_req_wstrb,
    output logic                  lsu_rsp_valid,
    output logic [31:0]           lsu_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb
);

    logic                  lsu_wr;
    logic [1:0]            rd_req;
    logic [1:0]            rd_gnt;
    logic [31:0]           fwd_rdata;

    logic                  ifu_rd_q, ifu_rd_d;
    logic                  lsu_rd_q, lsu_rd_d;
    logic                  wack_q, wack_d;
    logic                  hz_q, hz_d;
    logic [31:0]           hz_wdata_q;
    logic [3:0]            hz_wstrb_q;
    logic [ADDR_WIDTH-1:0] addrb_q;

    assign lsu_wr = lsu_req_valid & lsu_req_write;

    // Bit 0 is the IFU, bit 1 an LSU read; LSU writes use the other RAM port.
    assign rd_req = {lsu_req_valid & ~lsu_req_write, ifu_req_valid};

    rr_arb2 u_rr_arb2 (
        .clk_i  (clka),
        .rst_ni (rst_n),
        .req_i  (rd_req),
        .gnt_o  (rd_gnt)
    );

    assign ifu_req_ready = rd_gnt[0];
    assign lsu_req_ready = rd_gnt[1] | lsu_wr;

    assign ram_addra = lsu_req_addr;
    assign ram_dina  = lsu_req_wdata;
    assign ram_wea   = (rst_n && lsu_wr) ? lsu_req_wstrb : 4'b0000;

    always_comb begin
        ram_addrb = addrb_q;
        if (rd_gnt[0]) begin
            ram_addrb = ifu_req_addr;
        end else if (rd_gnt[1]) begin
            ram_addrb = lsu_req_addr;
        end
    end

    assign ifu_rd_d  = rd_gnt[0];
    assign lsu_rd_d  = rd_gnt[1];
    assign wack_d    = lsu_wr;
    // The RAM returns pre-write data on a same-cycle collision, so remember the write.
    assign hz_d      = lsu_wr & (|rd_gnt) & (ram_addrb == lsu_req_addr);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            ifu_rd_q   <= 1'b0;
            lsu_rd_q   <= 1'b0;
            wack_q     <= 1'b0;
            hz_q       <= 1'b0;
            hz_wdata_q <= '0;
            hz_wstrb_q <= '0;
            addrb_q    <= '0;
        end else begin
            ifu_rd_q   <= ifu_rd_d;
            lsu_rd_q   <= lsu_rd_d;
            wack_q     <= wack_d;
            hz_q       <= hz_d;
            hz_wdata_q <= lsu_req_wdata;
            hz_wstrb_q <= lsu_req_wstrb;
            addrb_q    <= ram_addrb;
        end
    end

    assign fwd_rdata = merge_bytes(ram_doutb, hz_wdata_q, hz_q ? hz_wstrb_q : 4'b0000);

    assign ifu_rsp_valid = ifu_rd_q;
    assign ifu_rsp_rdata = ifu_rd_q ? fwd_rdata : 32'h0;
    assign lsu_rsp_valid = lsu_rd_q | wack_q;
    assign lsu_rsp_rdata = lsu_rd_q ? fwd_rdata : 32'h0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - self-checking bench for bram_port_arbiter
module tb_bram_port_arbiter;

    localparam int AW = 14;

    logic          clka;
    logic          rst_n;
    logic          ifu_req_valid;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_req_addr;
    logic          ifu_rsp_valid;
    logic [31:0]   ifu_rsp_rdata;
    logic          lsu_req_valid;
    logic          lsu_req_ready;
    logic          lsu_req_write;
    logic [AW-1:0] lsu_req_addr;
    logic [31:0]   lsu_req_wdata;
    logic [3:0]    lsu_req_wstrb;
    logic          lsu_rsp_valid;
    logic [31:0]   lsu_rsp_rdata;
    logic [AW-1:0] ram_addra;
    logic [31:0]   ram_dina;
    logic [3:0]    ram_wea;
    logic [AW-1:0] ram_addrb;
    logic [31:0]   ram_doutb;

    int checks;
    int failures;

    bram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clka          (clka),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_rdata (ifu_rsp_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_write (lsu_req_write),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_wstrb (lsu_req_wstrb),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .ram_addra     (ram_addra),
        .ram_dina      (ram_dina),
        .ram_wea       (ram_wea),
        .ram_addrb     (ram_addrb),
        .ram_doutb     (ram_doutb)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Behavioural RAM: registered read port, byte-write port, read-before-write.
    bit [31:0]     mem [0:255];
    logic          pre_en;
    logic [7:0]    pre_addr;
    logic [31:0]   pre_data;

    always @(posedge clka) begin
        ram_doutb <= mem[ram_addrb[7:0]];
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end
        for (int b = 0; b < 4; b++) begin
            if (ram_wea[b]) mem[ram_addra[7:0]][8*b +: 8] <= ram_dina[8*b +: 8];
        end
    end

    // Reference model: memory image plus the "who lost the last contention" rule.
    bit [31:0] ref_mem [0:255];
    bit        m_lsu_turn;
    bit        g_i, g_l, contend;
    bit        exp_iv, exp_lv;
    bit [31:0] exp_id, exp_ld;

    task automatic model_reset();
        m_lsu_turn = 1'b0;
        exp_iv = 1'b0; exp_lv = 1'b0; exp_id = 32'h0; exp_ld = 32'h0;
    endtask

    task automatic predict();
        bit cand_l;
        cand_l  = lsu_req_valid && !lsu_req_write;
        contend = ifu_req_valid && cand_l;
        g_i = contend ? !m_lsu_turn : ifu_req_valid;
        g_l = contend ?  m_lsu_turn : cand_l;
    endtask

    task automatic drive(input bit iv, input int ia, input bit lv, input bit lw,
                         input int la, input bit [31:0] wd, input bit [3:0] ws);
        ifu_req_valid = iv;  ifu_req_addr = AW'(ia);
        lsu_req_valid = lv;  lsu_req_write = lw;  lsu_req_addr = AW'(la);
        lsu_req_wdata = wd;  lsu_req_wstrb = ws;
        #1;
        predict();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 32'h0, 4'h0);
    endtask

    // Advance one clock and update the model; responses are checkable on return.
    task automatic tick();
        bit wr;
        @(posedge clka);
        wr = lsu_req_valid && lsu_req_write;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (lsu_req_wstrb[b]) ref_mem[lsu_req_addr[7:0]][8*b +: 8] = lsu_req_wdata[8*b +: 8];
        end
        exp_iv = g_i;
        exp_id = g_i ? ref_mem[ifu_req_addr[7:0]] : 32'h0;
        exp_lv = g_l || wr;
        exp_ld = g_l ? ref_mem[lsu_req_addr[7:0]] : 32'h0;
        if (contend) m_lsu_turn = g_i;
        #1;
    endtask

    task automatic preload(input int a, input bit [31:0] v);
        idle();
        pre_en = 1'b1; pre_addr = 8'(a); pre_data = v;
        @(posedge clka);
        #1;
        pre_en = 1'b0;
        ref_mem[a] = v;
        exp_iv = 1'b0; exp_lv = 1'b0; exp_id = 32'h0; exp_ld = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 1, 1, 5, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (ram_wea !== 4'h0) begin
            failures++; $display("FAIL reset_wea: got %h expected 0", ram_wea);
        end
        checks++;
        if ({ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid, lsu_rsp_rdata} !== 66'h0) begin
            failures++;
            $display("FAIL reset_rsp: got iv=%b id=%h lv=%b ld=%h expected all 0",
                     ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid, lsu_rsp_rdata);
        end
        idle();
        @(posedge clka); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clka); #1;
    endtask

    task automatic test_ifu_read();
        preload(16, 32'hDEAD_BEEF);
        drive(1, 16, 0, 0, 0, 32'h0, 4'h0);
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            failures++; $display("FAIL ifu_ready: got %b expected 1", ifu_req_ready);
        end
        tick();
        idle();
        checks++;
        if ({ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            failures++;
            $display("FAIL ifu_read_rsp: got iv=%b id=%h lv=%b expected 1 deadbeef 0",
                     ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid);
        end
        tick();
    endtask

    task automatic test_contention();
        bit [1:0] want [4];
        want = '{2'b01, 2'b10, 2'b01, 2'b10};
        preload(1, 32'h1111_0001);
        preload(2, 32'h2222_0002);
        for (int c = 0; c < 4; c++) begin
            drive(1, 1, 1, 0, 2, 32'h0, 4'h0);
            checks++;
            if ({lsu_req_ready, ifu_req_ready} !== want[c]) begin
                failures++;
                $display("FAIL contend_grant[%0d]: got lsu/ifu=%b expected %b",
                         c, {lsu_req_ready, ifu_req_ready}, want[c]);
            end
            tick();
            checks++;
            if ({ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid, lsu_rsp_rdata} !==
                {want[c][0], want[c][0] ? 32'h1111_0001 : 32'h0,
                 want[c][1], want[c][1] ? 32'h2222_0002 : 32'h0}) begin
                failures++;
                $display("FAIL contend_rsp[%0d]: got iv=%b id=%h lv=%b ld=%h",
                         c, ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid, lsu_rsp_rdata);
            end
        end
        idle(); tick();
    endtask

    task automatic test_write_then_read();
        preload(32, 32'hAABB_CCDD);
        drive(0, 0, 1, 1, 32, 32'h1122_3344, 4'b0101);
        checks++;
        if (lsu_req_ready !== 1'b1 || ram_wea !== 4'b0101) begin
            failures++; $display("FAIL wr_accept: got ready=%b wea=%b expected 1 0101", lsu_req_ready, ram_wea);
        end
        tick();
        drive(0, 0, 1, 0, 32, 32'h0, 4'h0);
        checks++;
        if ({lsu_rsp_valid, lsu_rsp_rdata} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL wr_ack: got lv=%b ld=%h expected 1 0", lsu_rsp_valid, lsu_rsp_rdata);
        end
        tick();
        idle();
        checks++;
        if ({lsu_rsp_valid, lsu_rsp_rdata} !== {1'b1, 32'hAA22_CC44}) begin
            failures++; $display("FAIL wr_readback: got lv=%b ld=%h expected 1 aa22cc44", lsu_rsp_valid, lsu_rsp_rdata);
        end
        tick();
        // A zero-strobe write leaves the word alone but is still acknowledged.
        drive(0, 0, 1, 1, 32, 32'hFFFF_FFFF, 4'h0);
        tick();
        drive(0, 0, 1, 0, 32, 32'h0, 4'h0);
        checks++;
        if ({lsu_rsp_valid, lsu_rsp_rdata} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL wstrb0_ack: got lv=%b ld=%h expected 1 0", lsu_rsp_valid, lsu_rsp_rdata);
        end
        tick();
        idle();
        checks++;
        if (lsu_rsp_rdata !== 32'hAA22_CC44) begin
            failures++; $display("FAIL wstrb0_data: got %h expected aa22cc44", lsu_rsp_rdata);
        end
        tick();
    endtask

    task automatic test_collision();
        preload(48, 32'h0123_4567);
        drive(1, 48, 1, 1, 48, 32'hCAFE_F00D, 4'b1100);
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b11) begin
            failures++; $display("FAIL coll_ready: got ifu/lsu=%b expected 11", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        idle();
        checks++;
        if ({ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid, lsu_rsp_rdata} !==
            {1'b1, 32'hCAFE_4567, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL coll_fwd: got iv=%b id=%h lv=%b ld=%h expected 1 cafe4567 1 0",
                     ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid, lsu_rsp_rdata);
        end
        tick();
    endtask

    task automatic test_stream();
        int stalls;
        int errs;
        stalls = 0; errs = 0;
        for (int c = 0; c < 40; c++) begin
            drive(1, $urandom_range(0, 15), 1, 1, $urandom_range(16, 31), $urandom, 4'($urandom));
            if (!ifu_req_ready || !lsu_req_ready) stalls++;
            tick();
            checks++;
            if ({ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid, lsu_rsp_rdata} !== {exp_iv, exp_id, exp_lv, exp_ld}) begin
                failures++;
                $display("FAIL stream_rsp[%0d]: got iv=%b id=%h lv=%b ld=%h expected %b %h %b %h",
                         c, ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid, lsu_rsp_rdata,
                         exp_iv, exp_id, exp_lv, exp_ld);
            end
        end
        idle(); tick();
        checks++;
        if (stalls != 0) begin
            failures++; $display("FAIL stream_stalls: got %0d expected 0", stalls);
        end
        for (int a = 0; a < 32; a++) if (mem[a] != ref_mem[a]) errs++;
        checks++;
        if (errs != 0) begin
            failures++; $display("FAIL stream_ram: got %0d bad words expected 0", errs);
        end
    endtask

    task automatic test_random_mix();
        bit        iv, lv, lw;
        int        ia, la;
        bit [31:0] wd;
        bit [3:0]  ws;
        iv = 0; lv = 0; lw = 0; ia = 0; la = 0; wd = 0; ws = 0;
        for (int c = 0; c < 150; c++) begin
            if (!iv) begin iv = 1'($urandom); ia = $urandom_range(0, 7); end
            if (!lv) begin
                lv = 1'($urandom); lw = 1'($urandom); la = $urandom_range(0, 7);
                wd = $urandom; ws = 4'($urandom);
            end
            drive(iv, ia, lv, lw, la, wd, ws);
            checks++;
            if ({ifu_req_ready, lsu_req_ready} !== {g_i, g_l || (lv && lw)}) begin
                failures++;
                $display("FAIL mix_ready[%0d]: got ifu/lsu=%b%b expected %b%b",
                         c, ifu_req_ready, lsu_req_ready, g_i, g_l || (lv && lw));
            end
            if (g_i) iv = 0;
            if (g_l || (lv && lw)) lv = 0;
            tick();
            checks++;
            if ({ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid, lsu_rsp_rdata} !== {exp_iv, exp_id, exp_lv, exp_ld}) begin
                failures++;
                $display("FAIL mix_rsp[%0d]: got iv=%b id=%h lv=%b ld=%h expected %b %h %b %h",
                         c, ifu_rsp_valid, ifu_rsp_rdata, lsu_rsp_valid, lsu_rsp_rdata,
                         exp_iv, exp_id, exp_lv, exp_ld);
            end
        end
        idle(); tick();
    endtask

    task automatic test_reset_mid();
        // Contend once with IFU winning so the pointer would next favour the LSU.
        if (m_lsu_turn) begin
            drive(1, 1, 1, 0, 2, 32'h0, 4'h0); tick();
        end
        drive(1, 1, 1, 0, 2, 32'h0, 4'h0); tick();
        drive(1, 16, 0, 0, 0, 32'h0, 4'h0); tick();
        rst_n = 1'b0;
        drive(0, 0, 1, 1, 7, 32'h5555_5555, 4'hF);
        checks++;
        if ({ifu_rsp_valid, lsu_rsp_valid, ram_wea} !== 6'h0) begin
            failures++;
            $display("FAIL midreset_out: got iv=%b lv=%b wea=%b expected 0 0 0000",
                     ifu_rsp_valid, lsu_rsp_valid, ram_wea);
        end
        idle();
        @(posedge clka); #1;
        rst_n = 1'b1;
        model_reset();
        checks++;
        if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin
            failures++; $display("FAIL midreset_replay: got iv=%b lv=%b expected 00", ifu_rsp_valid, lsu_rsp_valid);
        end
        drive(1, 1, 1, 0, 2, 32'h0, 4'h0);
        checks++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL midreset_prio: got lsu/ifu=%b expected 01", {lsu_req_ready, ifu_req_ready});
        end
        tick();
        idle(); tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        pre_en = 1'b0; pre_addr = 8'h0; pre_data = 32'h0;
        model_reset();
        test_reset();
        test_ifu_read();
        test_contention();
        test_write_then_read();
        test_collision();
        test_stream();
        test_random_mix();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
